// File: rtl/csr_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_responder_if
// Purpose  : EX-stage CSR request bundle plus the host-side tohost handshake.
// Revision : 1.0
// ============================================================================
interface csr_responder_if #(
  parameter int DWIDTH = 32
) ();
  logic              we;
  logic              rd;
  logic [11:0]       addr;
  logic [2:0]        func;
  logic [DWIDTH-1:0] data_in;
  logic [DWIDTH-1:0] data_out;
  logic              stall;
  logic              inst_retire;
  logic              tohost_valid;
  logic [DWIDTH-1:0] tohost_data;
  logic              tohost_ready;

  // master = pipeline/host side, slave = responder
  modport master (
    output we, rd, addr, func, data_in, inst_retire, tohost_ready,
    input  data_out, stall, tohost_valid, tohost_data
  );

  modport slave (
    input  we, rd, addr, func, data_in, inst_retire, tohost_ready,
    output data_out, stall, tohost_valid, tohost_data
  );
endinterface
`default_nettype wire

// File: rtl/csr_responder.sv
`default_nettype none
// ============================================================================
// Module   : csr_responder
// Purpose  : Machine CSRs, 64-bit cycle/instret counters and a tohost FIFO.
// Revision : 1.0
// ============================================================================
module csr_responder #(
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  csr_responder_if.slave    bus
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

  localparam logic [11:0] c_MSCRATCH = 12'h340;
  localparam logic [11:0] c_TOHOST   = 12'h51E;
  localparam logic [11:0] c_CYCLE    = 12'hC00;
  localparam logic [11:0] c_CYCLEH   = 12'hC80;
  localparam logic [11:0] c_INSTRET  = 12'hC02;
  localparam logic [11:0] c_INSTRETH = 12'hC82;

  logic [DWIDTH-1:0]  r_mscratch;
  logic [DWIDTH-1:0]  r_tohost;
  logic [DWIDTH-1:0]  r_cycle_lo;
  logic [DWIDTH-1:0]  r_cycle_hi;
  logic [DWIDTH-1:0]  r_instret_lo;
  logic [DWIDTH-1:0]  r_instret_hi;
  logic [DWIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [DWIDTH-1:0] w_old;
  logic [DWIDTH-1:0] w_new;
  logic              w_is_rw;
  logic              w_is_rs;
  logic              w_is_rc;
  logic              w_writable;
  logic              w_full;
  logic              w_stall;
  logic              w_eff_we;
  logic              w_push;
  logic              w_pop;

  always_comb begin
    w_old = '0;
    case (bus.addr)
      c_MSCRATCH: w_old = r_mscratch;
      c_TOHOST:   w_old = r_tohost;
      c_CYCLE:    w_old = r_cycle_lo;
      c_CYCLEH:   w_old = r_cycle_hi;
      c_INSTRET:  w_old = r_instret_lo;
      c_INSTRETH: w_old = r_instret_hi;
      default:    w_old = '0;
    endcase
  end

  assign w_is_rw = (bus.func == 3'b001) || (bus.func == 3'b101);
  assign w_is_rs = (bus.func == 3'b010) || (bus.func == 3'b110);
  assign w_is_rc = (bus.func == 3'b011) || (bus.func == 3'b111);

  always_comb begin
    w_new = bus.data_in;
    if (w_is_rs) w_new = w_old | bus.data_in;
    if (w_is_rc) w_new = w_old & ~bus.data_in;
  end

  // Counters are read-only, so only these two addresses can take a write
  assign w_writable = (bus.addr == c_MSCRATCH) || (bus.addr == c_TOHOST);
  assign w_full     = (r_count == c_FULL);
  assign w_stall    = bus.we && (bus.addr == c_TOHOST) && w_full;
  assign w_eff_we   = bus.we && !w_stall && w_writable &&
                      (w_is_rw || ((w_is_rs || w_is_rc) && (bus.data_in != '0)));
  assign w_push     = w_eff_we && (bus.addr == c_TOHOST);
  assign w_pop      = (r_count != '0) && bus.tohost_ready;

  assign bus.data_out     = bus.rd ? w_old : '0;
  assign bus.stall        = w_stall;
  assign bus.tohost_valid = (r_count != '0);
  assign bus.tohost_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mscratch   <= '0;
      r_tohost     <= '0;
      r_cycle_lo   <= '0;
      r_cycle_hi   <= '0;
      r_instret_lo <= '0;
      r_instret_hi <= '0;
    end else begin
      {r_cycle_hi, r_cycle_lo} <= {r_cycle_hi, r_cycle_lo} + 1'b1;
      if (bus.inst_retire) begin
        {r_instret_hi, r_instret_lo} <= {r_instret_hi, r_instret_lo} + 1'b1;
      end
      if (w_eff_we && (bus.addr == c_MSCRATCH)) r_mscratch <= w_new;
      if (w_push) r_tohost <= w_new;
    end
  end

  // Power-of-two depth lets both pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_responder
// Purpose  : Directed bench with queued expectations checked by a monitor.
// Revision : 1.0
// ============================================================================
module tb_csr_responder;

  localparam logic [2:0]  c_RW  = 3'b001, c_RS  = 3'b010, c_RC  = 3'b011;
  localparam logic [2:0]  c_RWI = 3'b101, c_RSI = 3'b110, c_RCI = 3'b111;
  localparam logic [11:0] c_MS  = 12'h340, c_TH  = 12'h51E;
  localparam logic [11:0] c_CY  = 12'hC00, c_CYH = 12'hC80;
  localparam logic [11:0] c_IR  = 12'hC02, c_IRH = 12'hC82;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_host[$];

  csr_responder_if #(.DWIDTH(32)) bus ();

  csr_responder #(.DWIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted read and every host pop against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd && !bus.stall) begin
        if (exp_rd.size() == 0) check("rd_unexpected", bus.data_out, 32'hx);
        else check("data_out", bus.data_out, exp_rd.pop_front());
      end
      if (bus.tohost_valid && bus.tohost_ready) begin
        if (exp_host.size() == 0) check("pop_unexpected", bus.tohost_data, 32'hx);
        else check("tohost_data", bus.tohost_data, exp_host.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request is accepted
  task automatic csr(input logic w, input logic r, input logic [11:0] a,
                     input logic [2:0] f, input logic [31:0] d, input logic [31:0] e);
    int n;
    bus.we = w; bus.rd = r; bus.addr = a; bus.func = f; bus.data_in = d;
    if (r) exp_rd.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stall && n < 50);
    if (bus.stall) check("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.we = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic host_wr(input logic [31:0] v);
    exp_host.push_back(v);
    csr(1'b1, 1'b0, c_TH, c_RW, v, 32'h0);
  endtask

  initial begin
    logic [9:0] pat;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.we = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.func = '0; bus.data_in = '0;
    bus.inst_retire = 1'b0; bus.tohost_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, bus.tohost_valid}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_tohost_data", bus.tohost_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      csr(1'b0, 1'b1, c_CY, c_RS, 32'h0, 32'(i));
      check("idle_valid", {31'd0, bus.tohost_valid}, 32'd0);
      check("idle_stall", {31'd0, bus.stall}, 32'd0);
    end

    // mscratch read-modify-write
    csr(1'b1, 1'b1, c_MS, c_RW,  32'hDEADBEEF, 32'h0);
    csr(1'b1, 1'b1, c_MS, c_RS,  32'h10,       32'hDEADBEEF);
    csr(1'b1, 1'b1, c_MS, c_RC,  32'h0,        32'hDEADBEFF);
    csr(1'b0, 1'b1, c_MS, c_RS,  32'h0,        32'hDEADBEFF);
    csr(1'b1, 1'b1, c_MS, c_RCI, 32'h0F,       32'hDEADBEFF);
    csr(1'b1, 1'b1, c_MS, c_RSI, 32'h0,        32'hDEADBEF0);
    csr(1'b1, 1'b1, c_MS, c_RWI, 32'h1F,       32'hDEADBEF0);
    csr(1'b0, 1'b1, c_MS, c_RS,  32'h0,        32'h1F);
    bus.addr = c_MS; bus.rd = 1'b0;
    @(negedge clk);
    check("rd0_data_out", bus.data_out, 32'h0);
    @(posedge clk); #1;
    csr(1'b1, 1'b1, 12'h123, c_RW, 32'h55,   32'h0);
    csr(1'b0, 1'b1, 12'h123, c_RS, 32'h0,    32'h0);
    csr(1'b1, 1'b1, c_IRH,   c_RW, 32'hFFFF, 32'h0);
    csr(1'b0, 1'b1, c_IRH,   c_RS, 32'h0,    32'h0);

    // Fill the FIFO, then a fifth write must stall until a slot frees
    bus.tohost_ready = 1'b0;
    for (int i = 1; i <= 4; i++) host_wr(32'(i));
    exp_host.push_back(32'd5);
    bus.we = 1'b1; bus.addr = c_TH; bus.func = c_RW; bus.data_in = 32'd5;
    @(negedge clk);
    check("full_stall", {31'd0, bus.stall}, 32'd1);
    check("full_valid", {31'd0, bus.tohost_valid}, 32'd1);
    @(posedge clk); #1;
    bus.tohost_ready = 1'b1;
    @(negedge clk);
    check("stall_with_ready", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_released", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.we = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("drain_queue", 32'(exp_host.size()), 32'd0);
    check("drain_valid", {31'd0, bus.tohost_valid}, 32'd0);
    bus.tohost_ready = 1'b0;
    csr(1'b0, 1'b1, c_TH, c_RS, 32'h0, 32'd5);

    // Pointer wrap with toggling ready
    for (int i = 0; i < 10; i++) begin
      bus.tohost_ready = i[0];
      host_wr(32'h100 + 32'(i));
      check("count_bound", {31'd0, (dut.r_count > 3'd4)}, 32'd0);
    end
    bus.tohost_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("wrap_queue", 32'(exp_host.size()), 32'd0);
    exp_host.push_back(32'h139);
    csr(1'b1, 1'b1, c_TH, c_RS, 32'h30, 32'h109);
    repeat (3) @(posedge clk);
    #1;
    check("rs_push_queue", 32'(exp_host.size()), 32'd0);
    bus.tohost_ready = 1'b0;

    // instret: 7 retirements in 10 cycles
    pat = 10'b1101101011;
    for (int i = 0; i < 10; i++) begin
      bus.inst_retire = pat[i];
      @(posedge clk); #1;
    end
    bus.inst_retire = 1'b0;
    csr(1'b0, 1'b1, c_IR, c_RS, 32'h0, 32'd7);

    // Low-half wrap carries into the high half
    csr(1'b0, 1'b1, c_CYH, c_RS, 32'h0, 32'h0);
    @(negedge clk);
    force dut.r_cycle_lo = 32'hFFFF_FFFF;
    #1 release dut.r_cycle_lo;
    @(posedge clk); #1;
    csr(1'b0, 1'b1, c_CY,  c_RS, 32'h0, 32'h0);
    csr(1'b0, 1'b1, c_CYH, c_RS, 32'h0, 32'h1);

    // Reset with entries pending
    for (int i = 0; i < 3; i++) host_wr(32'hA1 + 32'(i));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.tohost_valid}, 32'd0);
    check("async_rst_data", bus.tohost_data, 32'd0);
    check("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    exp_host.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    csr(1'b0, 1'b1, c_CY,  c_RS, 32'h0, 32'h0);
    csr(1'b0, 1'b1, c_MS,  c_RS, 32'h0, 32'h0);
    csr(1'b0, 1'b1, c_TH,  c_RS, 32'h0, 32'h0);
    csr(1'b0, 1'b1, c_IR,  c_RS, 32'h0, 32'h0);
    csr(1'b0, 1'b1, c_CYH, c_RS, 32'h0, 32'h0);
    csr(1'b0, 1'b1, c_IRH, c_RS, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("final_valid", {31'd0, bus.tohost_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
